// File: rtl/alu_issue_ctrl_pkg.sv
// Shared decode constants, FSM encoding and legality helpers for the
// ALU issue/write-back controller.
package alu_issue_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_LSHI  = 4'b1000;
    localparam logic [3:0] OP_RSHI  = 4'b1110;
    localparam logic [3:0] OP_EXT   = 4'b1010;

    // one bit per opext value, set where that opext is legal
    localparam logic [15:0] RTYPE_EXT_OK = 16'h40EE;
    localparam logic [15:0] EXT_EXT_OK   = 16'h007A;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [15:0] w);
        case (w[15:12])
            OP_RTYPE:                                     return RTYPE_EXT_OK[w[7:4]];
            OP_EXT:                                       return EXT_EXT_OK[w[7:4]];
            OP_ADDI, OP_ADDUI, OP_ADDCI, OP_LSHI, OP_RSHI: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue handshake plus the ALU operand/result bus.
interface alu_issue_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_opext;
    logic [15:0] alu_s;
    logic [4:0]  alu_clfzn;

    modport master (
        output instr, instr_valid, alu_s, alu_clfzn,
        input  instr_ready, alu_a, alu_b, alu_opcode, alu_opext
    );

    modport slave (
        input  instr, instr_valid, alu_s, alu_clfzn,
        output instr_ready, alu_a, alu_b, alu_opcode, alu_opext
    );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// General register file: one synchronous write port, two operand read
// ports and a debug read port, all reads combinational.
module alu_regfile #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] dbg_data
);
    logic [NREGS-1:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (!rst_n)  regs        <= '0;
        else if (we) regs[waddr] <= wdata;
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accept an instruction, drive the ALU for one cycle,
// then write the held result and flags back. One instruction per 3 cycles.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus,
    output logic [4:0]      psr,
    output logic            done,
    output logic            illegal,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
);
    state_t        state, state_nxt;
    logic [15:0]   ir;
    logic [DW-1:0] res;
    logic [4:0]    flg;
    logic [DW-1:0] ra, rb;
    logic          legal, we;

    assign legal = is_legal(ir);

    alu_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (ir[11:8]),
        .wdata    (res),
        .ra_addr  (ir[11:8]),
        .rb_addr  (ir[3:0]),
        .dbg_addr (dbg_addr),
        .ra_data  (ra),
        .rb_data  (rb),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
            res   <= '0;
            flg   <= '0;
            psr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == S_EXEC) begin
                res <= bus.alu_s;
                flg <= bus.alu_clfzn;
            end
            if (we) psr <= flg;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_opcode  = '0;
        bus.alu_opext   = '0;
        done            = 1'b0;
        illegal         = 1'b0;
        we              = 1'b0;
        case (state)
            S_IDLE: begin
                bus.instr_ready = rst_n;
                if (bus.instr_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                bus.alu_opcode = ir[15:12];
                bus.alu_opext  = ir[7:4];
                bus.alu_a      = ra;
                case (ir[15:12])
                    OP_RTYPE, OP_EXT: bus.alu_b = rb;
                    OP_ADDI, OP_ADDCI: bus.alu_b = {{8{ir[7]}}, ir[7:0]};
                    default:           bus.alu_b = {8'h00, ir[7:0]};
                endcase
                state_nxt = S_WB;
            end
            S_WB: begin
                // a reset landing on the write-back edge must suppress all effects
                we        = legal & rst_n;
                done      = legal & rst_n;
                illegal   = ~legal & rst_n;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule
